// File: rtl/cia_timer_bank.sv
// cia_timer_bank: NUM_TIMERS cascadable down-counters with shared ICR/IMR on a phi2-qualified 6502 bus.
// Define CIA_TIMER_BANK_PIN_OUT_EN to enable the per-channel tmr_out pulse/toggle outputs.
module cia_timer_bank #(
  parameter int NUM_TIMERS  = 3,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  phi2_p,
  input  logic                  phi2_n,
  input  logic                  cs_n,
  input  logic                  rw,
  input  logic [7:0]            addr,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  input  logic                  cnt_in,
  output logic [NUM_TIMERS-1:0] tmr_out,
  output logic                  irq_n
);
  localparam int NBYTES = TIMER_WIDTH / 8;

  logic rd, wr, rd_icr, wr_icr;
  logic [TIMER_WIDTH-1:0] latch_q [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] latch_d [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] cnt_q [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] cnt_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0]  start_q, start_d, oneshot_q, oneshot_d;
  logic [NUM_TIMERS-1:0]  force_q, force_d, src_q, src_d;
  logic [NUM_TIMERS-1:0]  icr_q, icr_d, imr_q, imr_d, imr_val_q, imr_val_d;
  logic                   imr_pend_q, imr_pend_d, imr_set_q, imr_set_d;
  logic                   clr_pend_q, clr_pend_d, irq_n_q, irq_n_d;
  logic                   cnt_prev_q, cnt_prev_d, cnt_pend_q, cnt_pend_d, cnt_src;
  logic [7:0]             db_out_q, db_out_d, rdata;
  logic [NUM_TIMERS-1:0]  evt, uflow;
  logic                   carry;
`ifdef CIA_TIMER_BANK_PIN_OUT_EN
  logic [NUM_TIMERS-1:0]  pen_q, pen_d, tgl_q, tgl_d, tmr_q, tmr_d;
`endif

  assign rd      = phi2_n & ~cs_n & rw;
  assign wr      = phi2_n & ~cs_n & ~rw;
  assign rd_icr  = rd & (addr == 8'hFF);
  assign wr_icr  = wr & (addr == 8'hFF);
  assign cnt_src = cnt_pend_q | (cnt_in & ~cnt_prev_q);

  // Underflows ripple through the whole chain within the same phi2_p cycle.
  always_comb begin
    evt   = '0;
    uflow = '0;
    carry = cnt_src;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      evt[i]   = phi2_p & start_q[i] & (src_q[i] ? carry : 1'b1);
      uflow[i] = evt[i] & (cnt_q[i] == '0);
      carry    = uflow[i];
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      for (int b = 0; b < NBYTES; b++)
        if (addr == 8'(4 * i + b)) rdata = cnt_q[i][8*b +: 8];
      if (addr == 8'(128 + i)) begin
        rdata[0] = start_q[i];
        rdata[1] = oneshot_q[i];
        rdata[3] = src_q[i];
`ifdef CIA_TIMER_BANK_PIN_OUT_EN
        rdata[4] = pen_q[i];
        rdata[5] = tgl_q[i];
`endif
      end
    end
    if (addr == 8'hFF) begin
      rdata    = 8'(icr_q);
      rdata[7] = ~irq_n_q;
    end
  end

  always_comb begin
    latch_d    = latch_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    oneshot_d  = oneshot_q;
    force_d    = force_q;
    src_d      = src_q;
    icr_d      = icr_q;
    imr_d      = imr_q;
    imr_val_d  = imr_val_q;
    imr_pend_d = imr_pend_q;
    imr_set_d  = imr_set_q;
    clr_pend_d = clr_pend_q;
    irq_n_d    = irq_n_q;
    cnt_prev_d = cnt_in;
    cnt_pend_d = phi2_p ? 1'b0 : cnt_src;
    db_out_d   = rd ? rdata : db_out_q;
`ifdef CIA_TIMER_BANK_PIN_OUT_EN
    pen_d      = pen_q;
    tgl_d      = tgl_q;
    tmr_d      = tmr_q;
`endif

    if (phi2_p) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (force_q[i] || uflow[i]) cnt_d[i] = latch_q[i];
        else if (evt[i])            cnt_d[i] = cnt_q[i] - TIMER_WIDTH'(1);
        if (uflow[i] && oneshot_q[i]) start_d[i] = 1'b0;
`ifdef CIA_TIMER_BANK_PIN_OUT_EN
        tmr_d[i] = tgl_q[i] ? (tmr_q[i] ^ uflow[i]) : uflow[i];
`endif
      end
      force_d = '0;
      if (imr_pend_q)
        imr_d = imr_set_q ? (imr_q | imr_val_q) : (imr_q & ~imr_val_q);
      imr_pend_d = 1'b0;
      // Events in the clearing tick survive; irq_n only looks at the previous icr.
      icr_d = (clr_pend_q ? {NUM_TIMERS{1'b0}} : icr_q) | uflow;
      if (clr_pend_q)            irq_n_d = 1'b1;
      else if (|(imr_q & icr_q)) irq_n_d = 1'b0;
      clr_pend_d = 1'b0;
    end

    // Bus writes come last so a control write overrides a one-shot stop.
    for (int i = 0; i < NUM_TIMERS; i++) begin
      for (int b = 0; b < NBYTES; b++)
        if (wr && addr == 8'(4 * i + b)) latch_d[i][8*b +: 8] = db_in;
      if (wr && addr == 8'(4 * i + NBYTES - 1) && !start_q[i]) cnt_d[i] = latch_d[i];
      if (wr && addr == 8'(128 + i)) begin
        start_d[i]   = db_in[0];
        oneshot_d[i] = db_in[1];
        force_d[i]   = db_in[2];
        src_d[i]     = db_in[3];
`ifdef CIA_TIMER_BANK_PIN_OUT_EN
        pen_d[i]     = db_in[4];
        tgl_d[i]     = db_in[5];
        if (db_in[0] && !start_q[i] && db_in[5]) tmr_d[i] = 1'b1;
`endif
      end
    end
    if (wr_icr) begin
      imr_pend_d = 1'b1;
      imr_set_d  = db_in[7];
      imr_val_d  = db_in[NUM_TIMERS-1:0];
    end
    if (rd_icr) clr_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        latch_q[i] <= '1;
        cnt_q[i]   <= '1;
      end
      start_q    <= '0;
      oneshot_q  <= '0;
      force_q    <= '0;
      src_q      <= '0;
      icr_q      <= '0;
      imr_q      <= '0;
      imr_val_q  <= '0;
      imr_pend_q <= 1'b0;
      imr_set_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      irq_n_q    <= 1'b1;
      cnt_prev_q <= 1'b0;
      cnt_pend_q <= 1'b0;
      db_out_q   <= 8'h00;
    end else begin
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      oneshot_q  <= oneshot_d;
      force_q    <= force_d;
      src_q      <= src_d;
      icr_q      <= icr_d;
      imr_q      <= imr_d;
      imr_val_q  <= imr_val_d;
      imr_pend_q <= imr_pend_d;
      imr_set_q  <= imr_set_d;
      clr_pend_q <= clr_pend_d;
      irq_n_q    <= irq_n_d;
      cnt_prev_q <= cnt_prev_d;
      cnt_pend_q <= cnt_pend_d;
      db_out_q   <= db_out_d;
    end
  end

`ifdef CIA_TIMER_BANK_PIN_OUT_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pen_q <= '0;
      tgl_q <= '0;
      tmr_q <= '0;
    end else begin
      pen_q <= pen_d;
      tgl_q <= tgl_d;
      tmr_q <= tmr_d;
    end
  end

  assign tmr_out = tmr_q & pen_q;
`else
  assign tmr_out = '0;
`endif

  assign db_out = db_out_q;
  assign irq_n  = irq_n_q;
endmodule

// File: tb/tb_cia_timer_bank.sv
// Self-checking bench for cia_timer_bank: default 3x16-bit bank plus a 1x24-bit bank on the same bus.
// Each phi2 tick is: bus access on phi2_n, then one phi2_p count/commit strobe.
module tb_cia_timer_bank;
  logic       clk = 1'b0;
  logic       res, phi2_p, phi2_n, cs_n, rw, cnt_in;
  logic [7:0] addr, db_in, db_out, db_out2;
  logic [2:0] tmr_out;
  logic [0:0] tmr_out2;
  logic       irq_n, irq_n2;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] rd_data, rd_data2;
  logic       irq_s;
  logic [2:0] tmr_s;

  always #5 clk = ~clk;

  cia_timer_bank dut (
    .clk(clk), .res(res), .phi2_p(phi2_p), .phi2_n(phi2_n), .cs_n(cs_n), .rw(rw),
    .addr(addr), .db_in(db_in), .db_out(db_out), .cnt_in(cnt_in),
    .tmr_out(tmr_out), .irq_n(irq_n)
  );

  cia_timer_bank #(.NUM_TIMERS(1), .TIMER_WIDTH(24)) dut2 (
    .clk(clk), .res(res), .phi2_p(phi2_p), .phi2_n(phi2_n), .cs_n(cs_n), .rw(rw),
    .addr(addr), .db_in(db_in), .db_out(db_out2), .cnt_in(cnt_in),
    .tmr_out(tmr_out2), .irq_n(irq_n2)
  );

  task automatic do_tick(input logic acc, input logic is_rd, input logic [7:0] a,
                         input logic [7:0] d, input logic pulse);
    @(negedge clk);
    phi2_n = 1'b1; cs_n = ~acc; rw = is_rd; addr = a; db_in = d; cnt_in = pulse;
    @(negedge clk);
    phi2_n = 1'b0; cs_n = 1'b1; rw = 1'b1; cnt_in = 1'b0;
    rd_data  = db_out;
    rd_data2 = db_out2;
    @(negedge clk);
    phi2_p = 1'b1;
    @(negedge clk);
    phi2_p = 1'b0;
    irq_s = irq_n;
    tmr_s = tmr_out;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    do_tick(1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic bus_read(input logic [7:0] a);
    do_tick(1'b1, 1'b1, a, 8'h00, 1'b0);
  endtask

  task automatic idle_tick();
    do_tick(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    res = 1'b1; phi2_p = 1'b0; phi2_n = 1'b0; cs_n = 1'b1; rw = 1'b1;
    addr = 8'h00; db_in = 8'h00; cnt_in = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] ad [8] = '{8'h00, 8'h01, 8'h02, 8'h80, 8'hFF, 8'h40, 8'h0C, 8'h83};
    logic [7:0] ex [8] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] e;
    apply_reset();
    checks++; if (db_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_db_out: actual %h, expected 00", db_out); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_irq_n: actual %b, expected 1", irq_n); end
    checks++; if (tmr_out !== 3'b000) begin errors++; $display("[TB] FAIL reset_tmr_out: actual %b, expected 000", tmr_out); end
    checks++; if (irq_n2 !== 1'b1 || tmr_out2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut2: irq_n %b tmr_out %b, expected 1 0", irq_n2, tmr_out2); end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(ex[k]);
      bus_read(ad[k]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("[TB] FAIL reset_read addr %h: actual %h, expected %h", ad[k], rd_data, e); end
    end
  endtask

  task automatic test_phi2_count();
    logic [7:0] ad [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] ex [6] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h81, 8'h00};
    logic       ei [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] e;
    apply_reset();
    bus_write(8'hFF, 8'h81);
    bus_write(8'h00, 8'h03);
    bus_write(8'h01, 8'h00);
    bus_write(8'h80, 8'h01);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(ex[k]);
      bus_read(ad[k]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("[TB] FAIL count_read step %0d: actual %h, expected %h", k, rd_data, e); end
      checks++;
      if (irq_s !== ei[k]) begin errors++; $display("[TB] FAIL count_irq_n step %0d: actual %b, expected %b", k, irq_s, ei[k]); end
    end
  endtask

  task automatic test_cascade();
    logic [7:0] ex [13] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h03,
                            8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h03, 8'h02};
    logic [7:0] e;
    apply_reset();
    bus_write(8'h00, 8'h01);
    bus_write(8'h01, 8'h00);
    bus_write(8'h04, 8'h02);
    bus_write(8'h05, 8'h00);
    bus_write(8'h81, 8'h09);
    bus_write(8'h80, 8'h01);
    for (int k = 0; k < 13; k++) begin
      exp_q.push_back(ex[k]);
      bus_read((k == 12) ? 8'h04 : 8'hFF);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("[TB] FAIL cascade step %0d: actual %h, expected %h", k, rd_data, e); end
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] ad [11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h82, 8'h08, 8'h09, 8'hFF};
    logic [7:0] ex [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h02, 8'h05, 8'h00, 8'h00};
    logic [7:0] e;
    apply_reset();
    bus_write(8'h08, 8'h05);
    bus_write(8'h09, 8'h00);
    bus_write(8'h82, 8'h03);
    for (int k = 0; k < 11; k++) begin
      exp_q.push_back(ex[k]);
      bus_read(ad[k]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("[TB] FAIL one_shot step %0d addr %h: actual %h, expected %h", k, ad[k], rd_data, e); end
    end
  endtask

  task automatic test_irq_clear_race();
    logic       ac [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ex [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h81};
    logic       ei [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] e;
    apply_reset();
    bus_write(8'hFF, 8'h81);
    bus_write(8'h00, 8'h02);
    bus_write(8'h01, 8'h00);
    bus_write(8'h80, 8'h01);
    for (int k = 0; k < 7; k++) begin
      if (ac[k]) begin
        exp_q.push_back(ex[k]);
        bus_read(8'hFF);
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin errors++; $display("[TB] FAIL race_read step %0d: actual %h, expected %h", k, rd_data, e); end
      end else begin
        idle_tick();
      end
      checks++;
      if (irq_s !== ei[k]) begin errors++; $display("[TB] FAIL race_irq_n step %0d: actual %b, expected %b", k, irq_s, ei[k]); end
    end
  endtask

  task automatic test_force_load();
    logic [7:0] ad [5] = '{8'h01, 8'h00, 8'h01, 8'h80, 8'hFF};
    logic [7:0] ex [5] = '{8'h00, 8'h34, 8'h12, 8'h01, 8'h00};
    logic [7:0] e;
    apply_reset();
    bus_write(8'h00, 8'h05);
    bus_write(8'h01, 8'h00);
    bus_write(8'h80, 8'h01);
    bus_write(8'h00, 8'h34);
    bus_write(8'h01, 8'h12);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(ex[k]);
      bus_read(ad[k]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("[TB] FAIL force_load step %0d addr %h: actual %h, expected %h", k, ad[k], rd_data, e); end
      if (k == 0) bus_write(8'h80, 8'h05);
    end
  endtask

  task automatic test_width();
    logic       wr_s [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] ad   [11] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0C};
    logic [7:0] wd   [11] = '{8'h56, 8'h34, 8'h00, 8'h00, 8'h12, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ex1  [11] = '{8'h00, 8'h00, 8'h56, 8'h00, 8'h00, 8'h00, 8'h56, 8'h34, 8'h00, 8'h00, 8'h00};
    logic [7:0] ex2  [11] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00};
    logic [7:0] e1, e2;
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      if (wr_s[k]) begin
        bus_write(ad[k], wd[k]);
      end else begin
        exp_q.push_back(ex1[k]);
        exp2_q.push_back(ex2[k]);
        bus_read(ad[k]);
        e1 = exp_q.pop_front();
        e2 = exp2_q.pop_front();
        checks++;
        if (rd_data !== e1) begin errors++; $display("[TB] FAIL width16 addr %h: actual %h, expected %h", ad[k], rd_data, e1); end
        checks++;
        if (rd_data2 !== e2) begin errors++; $display("[TB] FAIL width24 addr %h: actual %h, expected %h", ad[k], rd_data2, e2); end
      end
    end
  endtask

  task automatic test_cnt_in();
    logic       pl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ex [4] = '{8'h05, 8'h04, 8'h04, 8'h03};
    logic [7:0] e;
    apply_reset();
    bus_write(8'h00, 8'h05);
    bus_write(8'h01, 8'h00);
    bus_write(8'h80, 8'h09);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ex[k]);
      do_tick(1'b1, 1'b1, 8'h00, 8'h00, pl[k]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("[TB] FAIL cnt_in step %0d: actual %h, expected %h", k, rd_data, e); end
    end
  endtask

  task automatic test_pin_out();
`ifdef CIA_TIMER_BANK_PIN_OUT_EN
    logic et [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic ep [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    bus_write(8'h00, 8'h01);
    bus_write(8'h01, 8'h00);
    bus_write(8'h80, 8'h31);
    checks++;
    if (tmr_s[0] !== 1'b1) begin errors++; $display("[TB] FAIL toggle_start: actual %b, expected 1", tmr_s[0]); end
    for (int k = 0; k < 4; k++) begin
      idle_tick();
      checks++;
      if (tmr_s[0] !== et[k]) begin errors++; $display("[TB] FAIL toggle step %0d: actual %b, expected %b", k, tmr_s[0], et[k]); end
    end
    bus_write(8'h04, 8'h01);
    bus_write(8'h05, 8'h00);
    bus_write(8'h81, 8'h11);
    checks++;
    if (tmr_s[1] !== ep[0]) begin errors++; $display("[TB] FAIL pulse step 0: actual %b, expected %b", tmr_s[1], ep[0]); end
    for (int k = 1; k < 4; k++) begin
      idle_tick();
      checks++;
      if (tmr_s[1] !== ep[k]) begin errors++; $display("[TB] FAIL pulse step %0d: actual %b, expected %b", k, tmr_s[1], ep[k]); end
    end
`else
    apply_reset();
    bus_write(8'h00, 8'h01);
    bus_write(8'h01, 8'h00);
    bus_write(8'h80, 8'h31);
    for (int k = 0; k < 3; k++) begin
      idle_tick();
      checks++;
      if (tmr_s !== 3'b000) begin errors++; $display("[TB] FAIL tmr_out_off step %0d: actual %b, expected 000", k, tmr_s); end
    end
    exp_q.push_back(8'h01);
    bus_read(8'h80);
    checks++;
    if (rd_data !== exp_q[0]) begin errors++; $display("[TB] FAIL ctrl_pin_bits: actual %h, expected %h", rd_data, exp_q[0]); end
    void'(exp_q.pop_front());
`endif
  endtask

  initial begin
    res = 1'b1; phi2_p = 1'b0; phi2_n = 1'b0; cs_n = 1'b1; rw = 1'b1;
    addr = 8'h00; db_in = 8'h00; cnt_in = 1'b0;
    $display("[TB] starting cia_timer_bank bench");
    test_reset();
    test_phi2_count();
    test_cascade();
    test_one_shot();
    test_irq_clear_race();
    test_force_load();
    test_width();
    test_cnt_in();
    test_pin_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/cia_timer_bank.md
Name: cia_timer_bank

Overview:
Parametrised successor to the CIA interval timers: a bank of NUM_TIMERS down-counters of TIMER_WIDTH bits, with shared interrupt control, sitting on the same phi2-qualified 6502 bus as the CIA.
- Adds two behaviours the single CIA timer pair lacks: arbitrary channel count and width, and per-channel cascade from the previous channel.
- Used for expansion/cartridge timer hardware and for MEGA65-side timing.

Parameters:
NUM_TIMERS, 3, number of channels; legal range 1..7.
TIMER_WIDTH, 16, counter/latch width in bits; legal values 8, 16, 24, 32.

Ports:
clk  in  1  system clock
res  in  1  asynchronous, active-high reset
phi2_p  in  1  count/commit strobe (phi2 rising edge)
phi2_n  in  1  bus access strobe (phi2 falling edge)
cs_n  in  1  chip select, active low
rw  in  1  1 = read, 0 = write
addr  in  8  register address
db_in  in  8  write data
db_out  out  8  read data, registered
cnt_in  in  1  external count input (channel 0 cascade source)
tmr_out  out  NUM_TIMERS  per-channel underflow outputs (see Optional Feature)
irq_n  out  1  interrupt, active low

Behaviour:
- Bus strobes: rd = phi2_n & !cs_n & rw; wr = phi2_n & !cs_n & !rw.
- Reset values (asynchronous, active-high): db_out=0, irq_n=1, tmr_out=0; all latches and counters all-ones; control registers=0; icr=0; imr=0.
- Register map:
  - 0x00+4*i+b: channel i, byte b (b=0..3). Write updates latch byte b. Read returns live counter byte b. Bytes at or above TIMER_WIDTH/8 read 0 and ignore writes.
  - 0x80+i: control register of channel i.
  - 0xFF: ICR/IMR.
  - Unmapped reads return 0.
- Control register bits:
  - [0] start.
  - [1] one-shot.
  - [2] force-load strobe; self-clears at the next phi2_p; reads 0.
  - [3] source: 0 = phi2_p; 1 = cascade. For channel i>0, cascade counts channel i-1 underflows. For channel 0, cascade counts cnt_in rising edges, sampled per clk and held until the next phi2_p.
  - [5:4] see Optional Feature.
  - [7:6] read 0.
- Count event: occurs on phi2_p when start=1 and the source is active.
  - A count event with counter==0 is an underflow. On underflow: counter<=latch; icr[i]<=1; if one-shot, start<=0.
  - A count event with counter!=0 decrements the counter.
  - Cascade is combinational within a tick: an underflow of channel i-1 counts in channel i in the same phi2_p. A 7-deep ripple must settle in one clk.
- Loading:
  - Force-load: counter<=latch at the next phi2_p. Takes priority over decrement and underflow reload. Still sets icr if an underflow coincides.
  - Writing the top used byte while start=0 loads counter<=latch, including the new byte, immediately.
  - Latch writes during running do not disturb the counter until the next reload.
- Width: counter arithmetic is modulo 2^TIMER_WIDTH. A latch of 0 underflows on every count event.
- ICR/IMR:
  - Write 0xFF: bit7=1 ORs db_in[NUM_TIMERS-1:0] into imr; bit7=0 clears those bits. Takes effect at the next phi2_p.
  - Read 0xFF: returns {~irq_n, 0s, icr}. Clears icr and sets irq_n=1 at the next phi2_p.
  - An event in the same tick as the clear stays set. irq_n re-asserts no earlier than the following phi2_p.
  - irq_n falls on the phi2_p after (imr & icr) != 0. It stays low until a read of 0xFF.
- A simultaneous write to control start=0 and an underflow in the same tick: the underflow reload and icr set happen, and start ends at 0.

Optional Feature:
Macro: CIA_TIMER_BANK_PIN_OUT_EN.
- Defined: control [4] enables tmr_out[i]; control [5] selects 0=pulse, 1=toggle.
  - Pulse mode: tmr_out[i]=1 for exactly one phi2_p period after an underflow.
  - Toggle mode: tmr_out[i] inverts on each underflow, and is forced to 1 on the write that sets start from 0 to 1.
  - Output is updated on phi2_p.
- Undefined: tmr_out is constant 0; control [5:4] ignore writes and read 0.

Test Plan:
1. Ch0 latch 0x0003, start, phi2_p source → counter reads 2,1,0, then 3. icr[0]=1 on the 4th tick. With imr bit0 set, irq_n=0 one tick later.
2. Ch1 cascade from ch0: ch0 latch 1, ch1 latch 2 → ch1 underflows every 6 phi2_p. icr=0x03 is reported on ch1's underflow ticks.
3. One-shot ch2 latch 5 → exactly one underflow after 6 ticks; control reads 0x02; counter holds 5.
4. Read 0xFF in the same tick as a ch0 underflow → returns the prior icr; icr[0] remains 1; irq_n stays 1 for one tick, then 0 again.
5. Force-load with latch 0x1234 while counter=0x0001 and running → counter=0x1234 next tick; no underflow reported.
6. TIMER_WIDTH=24, write bytes 0x56,0x34,0x12 while stopped → counter reads 0x123456; byte 3 reads 0. With the macro defined, toggle mode: tmr_out[0] toggles once per underflow.
